// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared constants and enums for the UART packet parser.
package uart_pkt_pkg;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   typedef enum logic [2:0] {S_SYNC, S_CMD, S_LEN, S_DATA, S_CHK} state_t;
   typedef enum logic [1:0] {ERR_TIMEOUT, ERR_BADLEN, ERR_BADCHK, ERR_OVERRUN} err_t;
endpackage

// File: rtl/pkt_buffer_ram.sv
// pkt_buffer_ram: payload store with one write port and a registered read port.
module pkt_buffer_ram #(
   parameter int DEPTH = 32,
   localparam int AW = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);
   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   always_ff @(posedge clk)
      r_rdata <= !rst_n ? 8'h00 : r_mem[i_raddr];
   assign o_rdata = r_rdata;
endmodule

// File: rtl/uart_packet_parser.sv
// uart_packet_parser: frames SYNC/CMD/LEN/payload/CHK byte stream into checked packets.
module uart_packet_parser import uart_pkt_pkg::*; #(
   parameter int MAX_LEN = 32,
   parameter int TIMEOUT_CYC = 100000,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   localparam int LW = $clog2(MAX_LEN + 1),
   localparam int AW = $clog2(MAX_LEN)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          pkt_valid,
   output logic [7:0]    pkt_cmd,
   output logic [LW-1:0] pkt_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   input  logic          pkt_ack,
   output logic          err_pulse,
   output logic [1:0]    err_code
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   state_t        r_state;
   logic [7:0]    r_chk, r_cmd, r_pkt_cmd;
   logic [LW-1:0] r_len, r_pkt_len;
   logic [AW-1:0] r_idx;
   logic [TW-1:0] r_tcnt;
   logic          r_pkt_valid, r_err_pulse;
   logic [1:0]    r_err_code;
   logic          w_pv, w_we, w_last;
   // an ack arriving with a SYNC byte frees the buffer before the sync is judged
   assign w_pv   = r_pkt_valid & ~pkt_ack;
   assign w_we   = rx_valid && r_state == S_DATA;
   assign w_last = LW'(r_idx) + LW'(1) == r_len;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_SYNC;
         r_chk       <= '0;
         r_cmd       <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_tcnt      <= '0;
         r_pkt_valid <= 1'b0;
         r_pkt_cmd   <= '0;
         r_pkt_len   <= '0;
         r_err_pulse <= 1'b0;
         r_err_code  <= '0;
      end else begin
         r_err_pulse <= 1'b0;
         if (pkt_ack && r_pkt_valid) r_pkt_valid <= 1'b0;
         if (rx_valid || r_state == S_SYNC) r_tcnt <= '0;
         else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
            r_tcnt      <= '0;
            r_state     <= S_SYNC;
            r_err_pulse <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
         end else r_tcnt <= r_tcnt + 1'b1;
         if (rx_valid) begin
            case (r_state)
               S_SYNC: if (rx_data == SYNC_BYTE) begin
                  if (w_pv) begin
                     r_err_pulse <= 1'b1;
                     r_err_code  <= ERR_OVERRUN;
                  end else begin
                     r_chk   <= '0;
                     r_state <= S_CMD;
                  end
               end
               S_CMD: begin
                  r_cmd   <= rx_data;
                  r_chk   <= r_chk ^ rx_data;
                  r_state <= S_LEN;
               end
               S_LEN: if (32'(rx_data) > MAX_LEN) begin
                  r_err_pulse <= 1'b1;
                  r_err_code  <= ERR_BADLEN;
                  r_state     <= S_SYNC;
               end else begin
                  r_len   <= LW'(rx_data);
                  r_chk   <= r_chk ^ rx_data;
                  r_idx   <= '0;
                  r_state <= rx_data == 8'h00 ? S_CHK : S_DATA;
               end
               S_DATA: begin
                  r_chk   <= r_chk ^ rx_data;
                  r_idx   <= r_idx + 1'b1;
                  r_state <= w_last ? S_CHK : S_DATA;
               end
               S_CHK: begin
                  if (rx_data == r_chk) begin
                     r_pkt_valid <= 1'b1;
                     r_pkt_cmd   <= r_cmd;
                     r_pkt_len   <= r_len;
                  end else begin
                     r_err_pulse <= 1'b1;
                     r_err_code  <= ERR_BADCHK;
                  end
                  r_state <= S_SYNC;
               end
               default: r_state <= S_SYNC;
            endcase
         end
      end
   end
   pkt_buffer_ram #(.DEPTH(MAX_LEN)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we),
      .i_waddr (r_idx),
      .i_wdata (rx_data),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );
   assign pkt_valid = r_pkt_valid;
   assign pkt_cmd   = r_pkt_cmd;
   assign pkt_len   = r_pkt_len;
   assign err_pulse = r_err_pulse;
   assign err_code  = r_err_code;
endmodule
